// File: rtl/mac_wave_sequencer.sv
// Bit-serial weight sequencer: feeds a MAC one weight-magnitude column per cycle, MSB first.
// Latency: out_valid in cycle NCOL+3 after accept (CLEAR, LOAD, NCOL x COMPUTE); fewer with WAVE_ZERO_SKIP_EN.
// Backpressure: one job in flight; in_ready only in IDLE, result held in DONE until out_ready.
module mac_wave_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_i,
  input  logic        [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_i,
  output logic signed [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_o,
  output logic        [VEC_LENGTH-1:0]               sign,
  output logic        [VEC_LENGTH-1:0]               w_bit,
  output logic        [2:0]                          column_idx,
  output logic                                       mac_en,
  output logic                                       mac_clr,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       busy
);

  localparam int NCOL = DATA_WIDTH - 1;
  localparam int CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q, wgt_q;
  logic [CW-1:0]                       col_q, col_d;
  logic                                first_vld, next_vld;
  logic [CW-1:0]                       first_col, next_col;

`ifdef WAVE_ZERO_SKIP_EN
  logic [NCOL-1:0] col_any;

  always_comb begin
    col_any = '0;
    for (int c = 0; c < NCOL; c++) begin
      for (int j = 0; j < VEC_LENGTH; j++) begin
        col_any[c] = col_any[c] | wgt_q[j][c];
      end
    end
  end

  // Highest non-zero column overall, and highest non-zero column below the current one.
  always_comb begin
    first_vld = 1'b0;
    first_col = '0;
    next_vld  = 1'b0;
    next_col  = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_any[c]) begin
        first_vld = 1'b1;
        first_col = CW'(c);
        if (CW'(c) < col_q) begin
          next_vld = 1'b1;
          next_col = CW'(c);
        end
      end
    end
  end
`else
  always_comb begin
    first_vld = 1'b1;
    first_col = CW'(NCOL - 1);
    next_vld  = (col_q != '0);
    next_col  = col_q - 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      act_q   <= '0;
      wgt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (state_q == S_IDLE && in_valid) begin
        act_q <= act_i;
        wgt_q <= weight_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CLEAR;
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: begin
        if (first_vld) begin
          state_d = S_COMPUTE;
          col_d   = first_col;
        end else begin
          state_d = S_DONE;
        end
      end
      S_COMPUTE: begin
        if (next_vld) col_d = next_col;
        else          state_d = S_DONE;
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // reset gates in_ready so nothing is advertised while the block is held in reset
  assign in_ready   = (state_q == S_IDLE) && reset;
  assign busy       = (state_q != S_IDLE);
  assign mac_clr    = (state_q == S_CLEAR);
  assign mac_en     = (state_q == S_COMPUTE);
  assign out_valid  = (state_q == S_DONE);
  assign column_idx = mac_en ? 3'(col_q) : 3'd0;
  assign act_o      = act_q;

  always_comb begin
    sign  = '0;
    w_bit = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      sign[j]  = wgt_q[j][DATA_WIDTH-1];
      w_bit[j] = mac_en ? wgt_q[j][col_q] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_wave_sequencer.sv
// Directed bench for mac_wave_sequencer with a behavioural shift-add MAC on its outputs.
module tb_mac_wave_sequencer;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid, in_ready;
  logic [15:0][7:0]      act_i, weight_i, act_o;
  logic [15:0]           sign, w_bit;
  logic [2:0]            column_idx;
  logic                  mac_en, mac_clr, out_valid, out_ready, busy;

  int n_checks = 0;
  int n_errors = 0;
  int acc = 0;
  int partial;
  int ncomp;
  int col_log [0:15];
  logic [15:0] sign_log;
  int done_cyc;

  mac_wave_sequencer #(.DATA_WIDTH(8), .VEC_LENGTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .act_i(act_i), .weight_i(weight_i), .act_o(act_o), .sign(sign),
    .w_bit(w_bit), .column_idx(column_idx), .mac_en(mac_en), .mac_clr(mac_clr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference MAC: sign-magnitude column weighted by its bit position.
  always_comb begin
    partial = 0;
    for (int j = 0; j < 16; j++) begin
      if (w_bit[j]) begin
        if (sign[j]) partial = partial - int'($signed(act_o[j]));
        else         partial = partial + int'($signed(act_o[j]));
      end
    end
  end

  always @(posedge clk) begin
    if (mac_clr)     acc <= 0;
    else if (mac_en) acc <= acc + (partial <<< column_idx);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_column_idx", column_idx, 0);
    check("rst_act_o", |act_o, 0);
    check("rst_sign", sign, 0);
    check("rst_w_bit", w_bit, 0);
  endtask

  function automatic logic [15:0][7:0] fill(input logic [7:0] v);
    logic [15:0][7:0] r;
    for (int j = 0; j < 16; j++) r[j] = v;
    return r;
  endfunction

  // Issues one job and watches it until out_valid (cycle count from the accept edge).
  task automatic run_job(input logic [15:0][7:0] a, input logic [15:0][7:0] w);
    @(negedge clk);
    act_i = a; weight_i = w; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    ncomp = 0;
    done_cyc = -1;
    sign_log = '0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 1) check("mac_clr_cycle1", mac_clr, 1);
      if (mac_en) begin
        if (ncomp == 0) sign_log = sign;
        if (ncomp < 16) col_log[ncomp] = int'(column_idx);
        ncomp++;
      end else begin
        check("w_bit_zero_outside_compute", w_bit, 0);
      end
      if (out_valid) done_cyc = k;
    end
    check("done_within_budget", done_cyc > 0, 1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  initial begin
    logic [15:0][7:0] a, w;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    act_i = '0; weight_i = '0;
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // all act=1, weight=0x03 -> 48
    run_job(fill(8'd1), fill(8'h03));
    check("t1_result", acc, 48);
`ifdef WAVE_ZERO_SKIP_EN
    check("t1_done_cycle", done_cyc, 5);
    check("t1_ncomp", ncomp, 2);
    for (int i = 0; i < 2; i++) check("t1_column_idx", col_log[i], 1 - i);
`else
    check("t1_done_cycle", done_cyc, 10);
    check("t1_ncomp", ncomp, 7);
    for (int i = 0; i < 7; i++) check("t1_column_idx", col_log[i], 6 - i);
`endif
    release_result();

    // lane0 -128 x (-5) = +640; lane1 negative zero contributes nothing
    a = '0; w = '0;
    a[0] = 8'h80; w[0] = 8'h85;
    a[1] = 8'd5;  w[1] = 8'h80;
    run_job(a, w);
    check("t2_result", acc, 640);
    check("t2_sign0", sign_log[0], 1);
    check("t2_sign1", sign_log[1], 1);
`ifdef WAVE_ZERO_SKIP_EN
    check("t2_done_cycle", done_cyc, 5);
`else
    check("t2_done_cycle", done_cyc, 10);
`endif
    release_result();

    // single MSB column
    run_job(fill(8'd2), fill(8'h40));
    check("t3_result", acc, 2048);
    check("t3_first_column", col_log[0], 6);
`ifdef WAVE_ZERO_SKIP_EN
    check("t3_done_cycle", done_cyc, 4);
    check("t3_ncomp", ncomp, 1);
`else
    check("t3_done_cycle", done_cyc, 10);
    check("t3_ncomp", ncomp, 7);
`endif
    release_result();

    // all negative zero -> result 0
    run_job(fill(8'd3), fill(8'h80));
    check("t4_result", acc, 0);
`ifdef WAVE_ZERO_SKIP_EN
    check("t4_done_cycle", done_cyc, 3);
    check("t4_ncomp", ncomp, 0);
`else
    check("t4_done_cycle", done_cyc, 10);
    check("t4_ncomp", ncomp, 7);
`endif
    release_result();

    // act=lane index, weight=1 -> 120; hold 5 cycles in DONE
    for (int j = 0; j < 16; j++) a[j] = 8'(j);
    run_job(a, fill(8'h01));
    check("t5_result", acc, 120);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_out_valid", out_valid, 1);
      check("t5_hold_act_o", act_o == a, 1);
      check("t5_hold_in_ready", in_ready, 0);
      check("t5_hold_result", acc, 120);
    end
    release_result();
    // second job: act=-1, weight=2 -> -32
    run_job(fill(8'hFF), fill(8'h02));
    check("t6_result", acc, -32);
    release_result();

    // reset in the 3rd COMPUTE cycle
    @(negedge clk);
    act_i = fill(8'd1); weight_i = fill(8'h7F); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t7_in_compute", mac_en, 1);
    check("t7_third_column", column_idx, 4);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t7_in_ready_after_release", in_ready, 1);
    run_job(fill(8'd1), fill(8'h7F));
    check("t7_result", acc, 2032);
    check("t7_done_cycle", done_cyc, 10);
    check("t7_ncomp", ncomp, 7);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_wave_sequencer.md
MAC_WAVE_SEQUENCER -- requirements
Module: mac_wave_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed activation width and sign-magnitude weight width; NCOL = DATA_WIDTH-1 magnitude bits, legal range 2..9.
REQ-002 SHALL have parameter VEC_LENGTH, default 16: lanes per vector.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream presents a job.
REQ-006 SHALL have port in_ready, output, 1 bit: sequencer can accept a job.
REQ-007 SHALL have port act_i, input, VEC_LENGTH x DATA_WIDTH signed: job activations.
REQ-008 SHALL have port weight_i, input, VEC_LENGTH x DATA_WIDTH: job weights; MSB is the sign, low NCOL bits are the magnitude.
REQ-009 SHALL have port act_o, output, VEC_LENGTH x DATA_WIDTH signed: held activations to the MAC.
REQ-010 SHALL have port sign, output, VEC_LENGTH x 1: per-lane weight sign to the MAC.
REQ-011 SHALL have port w_bit, output, VEC_LENGTH x 1: per-lane magnitude bit of the current column.
REQ-012 SHALL have port column_idx, output, 3 bits: bit position of the current column.
REQ-013 SHALL have port mac_en, output, 1 bit: MAC accumulate enable.
REQ-014 SHALL have port mac_clr, output, 1 bit: synchronous active-high clear to the MAC.
REQ-015 SHALL have port out_valid, output, 1 bit: MAC result holds the finished dot product.
REQ-016 SHALL have port out_ready, input, 1 bit: consumer has taken the result.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, CLEAR, LOAD, COMPUTE and DONE.
REQ-019 SHALL assert in_ready only in IDLE; a job is accepted on in_valid&&in_ready, act_i/weight_i are registered, and the state becomes CLEAR.
REQ-020 SHALL assert mac_clr for exactly the one CLEAR cycle, then enter LOAD, a gap cycle that lets the MAC's internal activation register capture act_o after its clear.
REQ-021 SHALL hold act_o and sign (weight MSB per lane) constant from the cycle after accept until leaving DONE.
REQ-022 SHALL, in COMPUTE, issue one column per cycle from MSB to LSB (c = NCOL-1 down to 0) with column_idx=c, w_bit[j]=weight[j][c] and mac_en=1.
REQ-023 SHALL drive mac_en=0 and w_bit all zero in every state other than COMPUTE.
REQ-024 SHALL go from the last COMPUTE cycle to DONE, so the MAC result is valid in the first DONE cycle; without skipping, out_valid rises in cycle 10 after the accept edge for DATA_WIDTH=8 (CLEAR=1, LOAD=2, COMPUTE=3..9).
REQ-025 SHALL hold out_valid in DONE until out_ready is sampled high, then return to IDLE; out_ready has no effect outside DONE.
REQ-026 SHALL treat a weight with zero magnitude and a set sign (negative zero) as contributing nothing.
REQ-027 SHALL ignore in_valid while busy; no job is queued or dropped silently, and upstream must hold it.

Reset
REQ-028 SHALL, on reset low, asynchronously enter IDLE regardless of state, including mid-COMPUTE.
REQ-029 SHALL, while reset is low, drive in_ready=0, busy=0, out_valid=0, mac_en=0, mac_clr=0, column_idx=0, and all-zero act_o, sign and w_bit.
REQ-030 SHALL have in_ready=1 in the first cycle after reset deasserts; an aborted job is lost and the MAC is cleared by the next job's CLEAR.

Configuration
REQ-031 SHALL, when WAVE_ZERO_SKIP_EN is defined, skip in COMPUTE any column whose w_bit vector is all zero; if every column is zero it SHALL go LOAD->DONE directly, with the result 0 from CLEAR.
REQ-032 SHALL, when WAVE_ZERO_SKIP_EN is undefined, always issue all NCOL columns; the result is identical in both builds and only latency differs.

Verification
REQ-033 SHALL check: all act=1, all weight=0x03 -> result 48, out_valid in cycle 10, column_idx sequence 6..0.
REQ-034 SHALL check: lane0 act=-128, weight 0x85, all other weights 0x00 -> result +640; sign[0]=1 during COMPUTE.
REQ-035 SHALL check, with WAVE_ZERO_SKIP_EN: all weight=0x40, act=2 -> exactly 1 COMPUTE cycle with column_idx=6, result 2048, out_valid in cycle 4; all weight=0x80 -> no COMPUTE cycle, result 0, out_valid in cycle 3.
REQ-036 SHALL check: out_ready low 5 cycles in DONE -> out_valid and act_o held and in_ready=0; out_ready=1 -> IDLE next cycle; a second job is accepted and its result is independent of the first.
REQ-037 SHALL check: reset low during the 3rd COMPUTE cycle -> all outputs zero immediately; a new job after release (all act=1, weight=0x7F) -> result 2032.
